// File: rtl/pitch_lookup_arbiter_pkg.sv
// Shared types and constants for the pitch lookup arbiter and its neighbours.
package pitch_lookup_arbiter_pkg;

  // Default widths, shared with the channel controllers and the pitch table.
  localparam int unsigned DefaultNoteWidth  = 6;
  localparam int unsigned DefaultPitchWidth = 16;

  // Lookup sequencing states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRespond = 2'd3
  } state_e;

  // Width of a channel index; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pitch_lookup_arbiter_rr_priority_select.sv
// Round-robin first-set search: scans pending starting at rr_ptr and wrapping.
module pitch_lookup_arbiter_rr_priority_select
  import pitch_lookup_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  localparam int unsigned IdxW = idx_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] i_pending,
  input  logic [IdxW-1:0]         i_rr_ptr,
  output logic [IdxW-1:0]         o_grant,
  output logic                    o_any
);

  int unsigned      idx;
  logic [IdxW-1:0]  idx_c;

  // First pending channel at or after rr_ptr wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    idx     = 0;
    idx_c   = '0;
    for (int unsigned off = 0; off < NUM_CHANNELS; off++) begin
      idx = 32'(i_rr_ptr) + off;
      if (idx >= NUM_CHANNELS) begin
        idx = idx - NUM_CHANNELS;
      end
      idx_c = IdxW'(idx);
      if (!o_any && i_pending[idx_c]) begin
        o_grant = idx_c;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pitch_lookup_arbiter.sv
// Shares one pitch lookup table between several channel controllers.
// Requests are latched per channel, granted round-robin, and the table's
// enable/valid handshake is sequenced with a timeout guard.
module pitch_lookup_arbiter
  import pitch_lookup_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned NOTE_WIDTH     = DefaultNoteWidth,
  parameter int unsigned PITCH_WIDTH    = DefaultPitchWidth,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_CHANNELS-1:0]          i_req,
  input  logic [NUM_CHANNELS*NOTE_WIDTH-1:0] i_note,
  output logic [NUM_CHANNELS-1:0]          o_ack,
  output logic [PITCH_WIDTH-1:0]           o_pitch,
  output logic                             o_lookup_enable,
  output logic [NOTE_WIDTH-1:0]            o_lookup_note,
  input  logic                             i_lookup_valid,
  input  logic [PITCH_WIDTH-1:0]           i_lookup_pitch,
  output logic [NUM_CHANNELS-1:0]          o_overrun,
  output logic                             o_timeout
);

  localparam int unsigned IdxW = idx_width(NUM_CHANNELS);

  state_e                  state_q;
  logic [IdxW-1:0]         grant_q;
  logic [IdxW-1:0]         rr_ptr_q;
  logic [IdxW-1:0]         rr_next;
  logic [7:0]              timer_q;
  logic [NOTE_WIDTH-1:0]   lookup_note_q;
  logic [PITCH_WIDTH-1:0]  pitch_q;
  logic                    timeout_q;

  logic [NUM_CHANNELS-1:0] pending_q;
  logic [NUM_CHANNELS-1:0] overrun_q;
  logic [NOTE_WIDTH-1:0]   notes_q [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] ack_vec;
  logic [IdxW-1:0]         sel_grant;
  logic                    sel_any;

  pitch_lookup_arbiter_rr_priority_select #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_select (
    .i_pending (pending_q),
    .i_rr_ptr  (rr_ptr_q),
    .o_grant   (sel_grant),
    .o_any     (sel_any)
  );

  // Ack is a one-hot decode of the granted channel while responding.
  always_comb begin
    ack_vec = '0;
    if (state_q == StRespond) begin
      ack_vec[grant_q] = 1'b1;
    end
  end

  // Pointer moves just past the channel that was served.
  always_comb begin
    if (grant_q == IdxW'(NUM_CHANNELS - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = grant_q + IdxW'(1);
    end
  end

  // Per-channel request capture; a fresh request beats a same-cycle ack clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      overrun_q <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        notes_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (i_req[i]) begin
          notes_q[i] <= i_note[i*NOTE_WIDTH +: NOTE_WIDTH];
          if (pending_q[i] && !ack_vec[i]) begin
            overrun_q[i] <= 1'b1;
          end
        end
      end
      pending_q <= (pending_q & ~ack_vec) | i_req;
    end
  end

  // Lookup sequencer: arbitrate, issue, wait for valid or timeout, respond.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      lookup_note_q <= '0;
      pitch_q       <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sel_any) begin
            grant_q       <= sel_grant;
            lookup_note_q <= notes_q[sel_grant];
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A valid on the final wait cycle still counts as a real result.
          if (i_lookup_valid) begin
            pitch_q <= i_lookup_pitch;
            state_q <= StRespond;
          end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
            pitch_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= StRespond;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StRespond: begin
          rr_ptr_q <= rr_next;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_ack           = ack_vec;
  assign o_pitch         = (state_q == StRespond) ? pitch_q : '0;
  assign o_lookup_enable = (state_q == StIssue);
  assign o_lookup_note   = lookup_note_q;
  assign o_overrun       = overrun_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_pitch_lookup_arbiter.sv
// Bench for pitch_lookup_arbiter: directed and random requests against a
// transaction-timing reference model, with a scripted pitch table.
module tb_pitch_lookup_arbiter;

  localparam int N   = 4;
  localparam int NW  = 6;
  localparam int PW  = 16;
  localparam int TMO = 15;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [N-1:0]      i_req = '0;
  logic [N*NW-1:0]   i_note = '0;
  logic [N-1:0]      o_ack;
  logic [PW-1:0]     o_pitch;
  logic              o_lookup_enable;
  logic [NW-1:0]     o_lookup_note;
  logic              i_lookup_valid = 1'b0;
  logic [PW-1:0]     i_lookup_pitch = '0;
  logic [N-1:0]      o_overrun;
  logic              o_timeout;

  always #5 i_clk = ~i_clk;

  pitch_lookup_arbiter #(
    .NUM_CHANNELS   (N),
    .NOTE_WIDTH     (NW),
    .PITCH_WIDTH    (PW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req           (i_req),
    .i_note          (i_note),
    .o_ack           (o_ack),
    .o_pitch         (o_pitch),
    .o_lookup_enable (o_lookup_enable),
    .o_lookup_note   (o_lookup_note),
    .i_lookup_valid  (i_lookup_valid),
    .i_lookup_pitch  (i_lookup_pitch),
    .o_overrun       (o_overrun),
    .o_timeout       (o_timeout)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: one lookup in flight, timed by absolute cycle numbers.
  bit          m_busy;
  int          m_en_at, m_ack_at, m_lat, m_grant, m_rr;
  logic [5:0]  m_gnote;
  bit          m_tmo_pend, m_tmo;
  logic [3:0]  m_pend, m_ovr;
  logic [5:0]  m_note [N];
  int          next_lat = 1;
  bit          rand_lat = 0;
  bit          noise_en = 0;

  function automatic logic [PW-1:0] pitch_of(input logic [5:0] n);
    return 16'hA5C3 ^ (16'(n) * 16'd517);
  endfunction

  function automatic logic [N*NW-1:0] note_at(input int ch, input logic [5:0] n);
    logic [N*NW-1:0] v;
    v = '0;
    v[ch*NW +: NW] = n;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_en_at = -100; m_ack_at = -100; m_lat = 1; m_grant = 0; m_rr = 0;
    m_gnote = '0; m_tmo_pend = 0; m_tmo = 0; m_pend = '0; m_ovr = '0;
    for (int i = 0; i < N; i++) m_note[i] = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic [N-1:0] req, input logic [N*NW-1:0] notes);
    logic [N-1:0]  e_ack;
    logic [PW-1:0] e_pitch;
    logic          e_en, tbl_valid, noise;
    e_ack = '0;
    if (m_busy && cyc == m_ack_at) e_ack[m_grant] = 1'b1;
    e_pitch   = (e_ack != 0 && !m_tmo_pend) ? pitch_of(m_gnote) : '0;
    e_en      = m_busy && cyc == m_en_at;
    tbl_valid = m_busy && m_lat <= TMO && cyc == m_en_at + m_lat;
    noise     = noise_en && (!m_busy || cyc == m_en_at || cyc == m_ack_at)
                && ($urandom_range(0, 2) == 0);
    i_req          = req;
    i_note         = notes;
    i_lookup_valid = tbl_valid || noise;
    i_lookup_pitch = tbl_valid ? pitch_of(o_lookup_note) : 16'($urandom);
    @(negedge i_clk);
    chk("ack", 32'(o_ack), 32'(e_ack));
    chk("pitch", 32'(o_pitch), 32'(e_pitch));
    chk("enable", 32'(o_lookup_enable), 32'(e_en));
    chk("overrun", 32'(o_overrun), 32'(m_ovr));
    chk("timeout", 32'(o_timeout), 32'(m_tmo));
    if (m_busy && cyc >= m_en_at && cyc < m_ack_at)
      chk("lookup_note", 32'(o_lookup_note), 32'(m_gnote));
    // Arbitration uses pending as registered before this cycle's requests.
    if (!m_busy && m_pend != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (m_pend[(m_rr + k) % N]) m_grant = (m_rr + k) % N;
      end
      m_gnote    = m_note[m_grant];
      m_busy     = 1;
      m_en_at    = cyc + 1;
      m_lat      = rand_lat ? int'($urandom_range(1, 17)) : next_lat;
      m_tmo_pend = m_lat > TMO;
      m_ack_at   = cyc + 2 + (m_lat > TMO ? TMO : m_lat);
    end else if (m_busy && m_tmo_pend && cyc == m_ack_at - 1) begin
      m_tmo = 1;
    end else if (m_busy && cyc == m_ack_at) begin
      m_busy = 0;
      m_rr   = (m_grant + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (m_pend[i] && !e_ack[i]) m_ovr[i] = 1'b1;
        m_note[i] = notes[i*NW +: NW];
      end
    end
    m_pend = (m_pend & ~e_ack) | req;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  initial begin
    int done;
    logic r;
    model_reset();
    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_pitch", 32'(o_pitch), 32'd0);
    chk("rst_enable", 32'(o_lookup_enable), 32'd0);
    chk("rst_note", 32'(o_lookup_note), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst = 1'b0;
    idle(3);

    // Single request, table latency 1.
    next_lat = 1;
    step(4'b0001, note_at(0, 6'd9));
    idle(8);

    // All channels at once, served in order.
    step(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1});
    idle(20);

    // Fairness: ch0 re-requests on its own ack while ch2 waits.
    step(4'b0001, note_at(0, 6'd10));
    step(4'b0100, note_at(2, 6'd20));
    done = 0;
    for (int i = 0; i < 30; i++) begin
      r = (done < 2) && m_busy && cyc == m_ack_at && m_grant == 0;
      if (r) done++;
      step(r ? 4'b0001 : 4'b0000, note_at(0, 6'(11 + done)));
    end
    idle(6);

    // Overrun: two pulses on ch1 while ch0 holds the table.
    next_lat = 6;
    step(4'b0001, note_at(0, 6'd3));
    step(4'b0000, '0);
    step(4'b0010, note_at(1, 6'd5));
    step(4'b0000, '0);
    step(4'b0010, note_at(1, 6'd7));
    idle(25);

    // Request coinciding with its own ack: a second ack, no overrun.
    next_lat = 2;
    step(4'b1000, note_at(3, 6'd12));
    done = 0;
    for (int i = 0; i < 20; i++) begin
      r = (done == 0) && m_busy && cyc == m_ack_at && m_grant == 3;
      if (r) done = 1;
      step(r ? 4'b1000 : 4'b0000, note_at(3, 6'd13));
    end

    // Timeout, then a normal lookup; timeout flag stays sticky.
    next_lat = 99;
    step(4'b0100, note_at(2, 6'd33));
    idle(22);
    next_lat = 1;
    step(4'b0100, note_at(2, 6'd34));
    idle(8);

    // Random traffic with random table latency and stray valids.
    rand_lat = 1;
    noise_en = 1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000, 24'($urandom));
    end
    noise_en = 0;
    idle(100);

    // Async reset in the middle of a wait.
    rand_lat = 0;
    next_lat = 8;
    step(4'b0010, note_at(1, 6'd40));
    idle(4);
    i_req = '0;
    i_lookup_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("arst_ack", 32'(o_ack), 32'd0);
    chk("arst_enable", 32'(o_lookup_enable), 32'd0);
    chk("arst_overrun", 32'(o_overrun), 32'd0);
    chk("arst_timeout", 32'(o_timeout), 32'd0);
    #1 i_rst = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    cyc++;
    idle(6);
    next_lat = 1;
    step(4'b0010, note_at(1, 6'd41));
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
